// File: rtl/exc_status_unit.sv
// exc_status_unit: sticky exception flags, cause priority encoder, EPC register
// and deferred retire of serviced causes for the single-cycle MIPS core.
module exc_status_unit #(
  parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
  parameter int          VEC_SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall_i,
  input  logic        invalid_i,
  input  logic        overflow_i,
  input  logic        ext_int_i,
  input  logic        exdone_i,
  input  logic        syscall_clear_i,
  input  logic        invalid_clear_i,
  input  logic        overflow_clear_i,
  input  logic        extint_clear_i,
  input  logic        in_handler_i,
  input  logic        epc_we_i,
  input  logic        epc_re_i,
  input  logic [31:0] pc_in_i,
  output logic [31:0] epc_o,
  output logic [1:0]  id_o,
  output logic        int_signal_o,
  output logic [3:0]  pending_o
);
  logic [3:0]  pending_q, pending_d, clr_q, clr_d;
  logic [31:0] saved_pc_q, saved_pc_d;
  logic        done_q, done_d, consume;
  always_comb begin
    consume    = done_q & ~in_handler_i;
    // a raw request on the retiring edge re-sets its flag, so no event is lost
    pending_d  = {ext_int_i, overflow_i, invalid_i, syscall_i}
               | (pending_q & ~(consume ? clr_q : 4'b0000));
    done_d     = exdone_i ? 1'b1 : (consume ? 1'b0 : done_q);
    clr_d      = exdone_i ? {extint_clear_i, overflow_clear_i, invalid_clear_i, syscall_clear_i}
                          : (consume ? 4'b0000 : clr_q);
    saved_pc_d = epc_we_i ? pc_in_i : saved_pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      clr_q      <= '0;
      done_q     <= 1'b0;
      saved_pc_q <= '0;
    end else begin
      pending_q  <= pending_d;
      clr_q      <= clr_d;
      done_q     <= done_d;
      saved_pc_q <= saved_pc_d;
    end
  end
  always_comb begin
    pending_o    = pending_q;
    int_signal_o = |pending_q;
    id_o         = pending_q[0] ? 2'd0 : pending_q[1] ? 2'd1 : pending_q[2] ? 2'd2
                 : pending_q[3] ? 2'd3 : 2'd0;
    epc_o        = epc_re_i ? saved_pc_q : VEC_BASE + ({30'd0, id_o} << VEC_SHIFT);
  end
endmodule

// File: tb/tb_exc_status_unit.sv
// tb_exc_status_unit: directed scoreboard bench for exc_status_unit.
module tb_exc_status_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        syscall, invalid, overflow, ext_int, exdone;
  logic        sc_clr, inv_clr, ov_clr, ei_clr, in_handler, epc_we, epc_re;
  logic [31:0] pc_in, epc;
  logic [1:0]  id;
  logic        int_signal;
  logic [3:0]  pending;
  int          errors = 0, checks = 0;

  typedef struct {
    string       tag;
    logic [3:0]  pend;
    logic [1:0]  id;
    logic        intr;
    logic [31:0] epc;
  } exp_t;
  exp_t sb[$];

  exc_status_unit dut (
    .clk(clk), .rst_n(rst_n),
    .syscall_i(syscall), .invalid_i(invalid), .overflow_i(overflow), .ext_int_i(ext_int),
    .exdone_i(exdone), .syscall_clear_i(sc_clr), .invalid_clear_i(inv_clr),
    .overflow_clear_i(ov_clr), .extint_clear_i(ei_clr), .in_handler_i(in_handler),
    .epc_we_i(epc_we), .epc_re_i(epc_re), .pc_in_i(pc_in),
    .epc_o(epc), .id_o(id), .int_signal_o(int_signal), .pending_o(pending)
  );

  always #5 clk = ~clk;

  task automatic idle();
    {syscall, invalid, overflow, ext_int, exdone} = '0;
    {sc_clr, inv_clr, ov_clr, ei_clr, in_handler, epc_we, epc_re} = '0;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] p, input logic [1:0] i,
                            input logic n, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.pend = p; x.id = i; x.intr = n; x.epc = e;
    sb.push_back(x);
  endtask

  task automatic check_front();
    exp_t x;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: empty queue, got nothing required an entry");
      return;
    end
    x = sb.pop_front();
    checks++;
    assert (pending === x.pend) else begin
      errors++; $error("FAIL %s pending: got %b required %b", x.tag, pending, x.pend);
    end
    checks++;
    assert (id === x.id) else begin
      errors++; $error("FAIL %s id: got %b required %b", x.tag, id, x.id);
    end
    checks++;
    assert (int_signal === x.intr) else begin
      errors++; $error("FAIL %s int_signal: got %b required %b", x.tag, int_signal, x.intr);
    end
    checks++;
    assert (epc === x.epc) else begin
      errors++; $error("FAIL %s epc: got %h required %h", x.tag, epc, x.epc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    // reset with random inputs, checked asynchronously and across held edges
    {syscall, invalid, overflow, ext_int, exdone} = 5'($urandom);
    {sc_clr, inv_clr, ov_clr, ei_clr, in_handler, epc_we, epc_re} = 7'($urandom);
    pc_in = $urandom;
    #3;
    expect_out("reset_async", 4'b0000, 2'd0, 1'b0, epc_re ? 32'h0 : 32'h100);
    check_front();
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset_held", 4'b0000, 2'd0, 1'b0, epc_re ? 32'h0 : 32'h100);
    check_front();
    idle();
    pc_in = 32'h0;
    @(negedge clk) rst_n = 1'b1;
    #1;
    expect_out("idle1", 4'b0000, 2'd0, 1'b0, 32'h100); step();
    expect_out("idle2", 4'b0000, 2'd0, 1'b0, 32'h100); step();

    // single overflow pulse, sticky
    overflow = 1'b1;
    expect_out("ovf_set", 4'b0100, 2'd2, 1'b1, 32'h120); step();
    overflow = 1'b0;
    expect_out("ovf_hold1", 4'b0100, 2'd2, 1'b1, 32'h120); step();
    expect_out("ovf_hold2", 4'b0100, 2'd2, 1'b1, 32'h120); step();

    // retire overflow: capture edge, then clear edge
    exdone = 1'b1; ov_clr = 1'b1;
    expect_out("ovf_capture", 4'b0100, 2'd2, 1'b1, 32'h120); step();
    idle();
    expect_out("ovf_cleared", 4'b0000, 2'd0, 1'b0, 32'h100); step();

    // short pulse between edges is not captured
    #2 invalid = 1'b1;
    #2 invalid = 1'b0;
    expect_out("glitch", 4'b0000, 2'd0, 1'b0, 32'h100); step();

    // priority: invalid over ext_int, then retire invalid
    invalid = 1'b1; ext_int = 1'b1;
    expect_out("prio", 4'b1010, 2'd1, 1'b1, 32'h110); step();
    idle(); exdone = 1'b1; inv_clr = 1'b1;
    expect_out("inv_capture", 4'b1010, 2'd1, 1'b1, 32'h110); step();
    idle();
    expect_out("inv_retired", 4'b1000, 2'd3, 1'b1, 32'h130); step();

    // EPC save and read back
    pc_in = 32'h0000_0040; epc_we = 1'b1;
    expect_out("epc_save", 4'b1000, 2'd3, 1'b1, 32'h130); step();
    epc_we = 1'b0; epc_re = 1'b1; pc_in = 32'hDEAD_BEEF;
    expect_out("epc_read", 4'b1000, 2'd3, 1'b1, 32'h40); step();
    pc_in = 32'h1234_5678;
    expect_out("epc_hold", 4'b1000, 2'd3, 1'b1, 32'h40); step();
    epc_re = 1'b0; exdone = 1'b1; ei_clr = 1'b1;
    expect_out("ei_capture", 4'b1000, 2'd3, 1'b1, 32'h130); step();
    idle();
    expect_out("ei_retired", 4'b0000, 2'd0, 1'b0, 32'h100); step();

    // deferred clear while in_handler stays high
    syscall = 1'b1;
    expect_out("sc_set", 4'b0001, 2'd0, 1'b1, 32'h100); step();
    idle(); exdone = 1'b1; sc_clr = 1'b1; in_handler = 1'b1;
    expect_out("defer1", 4'b0001, 2'd0, 1'b1, 32'h100); step();
    exdone = 1'b0; sc_clr = 1'b0;
    expect_out("defer2", 4'b0001, 2'd0, 1'b1, 32'h100); step();
    expect_out("defer3", 4'b0001, 2'd0, 1'b1, 32'h100); step();
    in_handler = 1'b0;
    expect_out("defer_clear", 4'b0000, 2'd0, 1'b0, 32'h100); step();
    syscall = 1'b1;
    expect_out("sc_reset", 4'b0001, 2'd0, 1'b1, 32'h100); step();
    syscall = 1'b0;
    expect_out("no_stale_done", 4'b0001, 2'd0, 1'b1, 32'h100); step();

    // set/clear collision: set wins
    exdone = 1'b1; sc_clr = 1'b1;
    expect_out("col_capture", 4'b0001, 2'd0, 1'b1, 32'h100); step();
    idle(); syscall = 1'b1;
    expect_out("col_setwins", 4'b0001, 2'd0, 1'b1, 32'h100); step();
    idle();
    expect_out("col_after", 4'b0001, 2'd0, 1'b1, 32'h100); step();

    // mid-handler async reset with a captured retire pending
    overflow = 1'b1; exdone = 1'b1; sc_clr = 1'b1; in_handler = 1'b1;
    expect_out("pre_abort", 4'b0101, 2'd0, 1'b1, 32'h100); step();
    idle(); in_handler = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    expect_out("abort_async", 4'b0000, 2'd0, 1'b0, 32'h100); check_front();
    @(negedge clk) rst_n = 1'b1;
    invalid = 1'b1; in_handler = 1'b0;
    expect_out("post_abort", 4'b0010, 2'd1, 1'b1, 32'h110); step();
    idle();
    expect_out("post_abort_hold", 4'b0010, 2'd1, 1'b1, 32'h110); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
